fir_acc_engine: RTL and testbench

//  Accelerator-side endpoint of the router's FIR FIFO pair: pops words from the to-FIR FIFO,

---
 rtl/fir_acc_engine.sv | 183 ++++++++++++++++++
 tb/tb_fir_acc_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_acc_engine.sv
// rtl/fir_acc_engine.sv - TAPS-tap signed FIR endpoint between the to-FIR and from-FIR FIFOs
//
// Each job starts with TAPS coefficient words, then a stream of sample words. Every
// sample produces one saturated 32-bit result pushed to the from-FIR FIFO.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-low reset
//   fir_enable        job active level from the router
//   to_fir_empty      to-FIR FIFO empty flag
//   acc_fir_data_out  to-FIR FIFO read data, valid the cycle after acc_fir_get
//   acc_fir_get       pop pulse to the to-FIR FIFO
//   from_fir_full     from-FIR FIFO full flag
//   acc_fir_put       push pulse to the from-FIR FIFO
//   acc_fir_data_in   result word, held until the next result is computed
//   busy              high whenever the engine is not idle
module fir_acc_engine #(
    parameter int TAPS     = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fir_enable,
    input  logic        to_fir_empty,
    input  logic [31:0] acc_fir_data_out,
    output logic        acc_fir_get,
    input  logic        from_fir_full,
    output logic        acc_fir_put,
    output logic [31:0] acc_fir_data_in,
    output logic        busy
);

    localparam int KW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW    = 2 * SAMPLE_W;
    localparam int ACC_W = PW + KW;
    // Saturation compares need at least 33 signed bits to represent both 32-bit bounds.
    localparam int EXT_W = (ACC_W > 33) ? ACC_W : 33;

    localparam logic [KW-1:0]           LAST    = KW'(TAPS - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W - 32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W - 32){1'b1}}, 32'h8000_0000};

    typedef enum logic [2:0] {
        IDLE,
        C_REQ,
        C_CAP,
        S_REQ,
        S_CAP,
        MAC,
        PUSH
    } state_t;

    state_t state;
    state_t next_state;

    // idx addresses the coefficient being loaded during C_* and the tap being summed in MAC.
    logic [KW-1:0]                idx;
    logic signed [SAMPLE_W-1:0]   coef [TAPS];
    logic signed [SAMPLE_W-1:0]   x    [TAPS];
    logic signed [ACC_W-1:0]      acc;

    logic signed [PW-1:0]         prod;
    logic signed [ACC_W-1:0]      acc_sum;
    logic signed [EXT_W-1:0]      sum_ext;
    logic [31:0]                  sat_val;
    logic [SAMPLE_W-1:0]          word_lo;

    assign word_lo = acc_fir_data_out[SAMPLE_W-1:0];

    always_comb begin
        prod    = PW'(coef[idx]) * PW'(x[idx]);
        acc_sum = acc + ACC_W'(prod);
        sum_ext = EXT_W'(acc_sum);
        if (sum_ext > SAT_MAX) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (sum_ext < SAT_MIN) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = sum_ext[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (fir_enable) next_state = C_REQ;
            end
            C_REQ: begin
                if (!fir_enable)        next_state = IDLE;
                else if (!to_fir_empty) next_state = C_CAP;
            end
            C_CAP: begin
                if (!fir_enable)        next_state = IDLE;
                else if (idx == LAST)   next_state = S_REQ;
                else                    next_state = C_REQ;
            end
            S_REQ: begin
                if (!fir_enable)        next_state = IDLE;
                else if (!to_fir_empty) next_state = S_CAP;
            end
            S_CAP: begin
                next_state = MAC;
            end
            MAC: begin
                if (idx == LAST) next_state = PUSH;
            end
            PUSH: begin
                if (!from_fir_full) next_state = S_REQ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pulses are gated by reset so an abandoned job never issues a partial get or put.
    always_comb begin
        acc_fir_get = 1'b0;
        acc_fir_put = 1'b0;
        if (reset) begin
            acc_fir_get = (state == C_REQ || state == S_REQ) && fir_enable && !to_fir_empty;
            acc_fir_put = (state == PUSH) && !from_fir_full;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx             <= '0;
            acc             <= '0;
            acc_fir_data_in <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
                x[i]    <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (fir_enable) begin
                        idx <= '0;
                        for (int i = 0; i < TAPS; i++) begin
                            x[i] <= '0;
                        end
                    end
                end
                C_CAP: begin
                    if (fir_enable) begin
                        coef[idx] <= word_lo;
                        idx       <= idx + KW'(1);
                    end
                end
                S_CAP: begin
                    x[0] <= word_lo;
                    for (int i = 1; i < TAPS; i++) begin
                        x[i] <= x[i-1];
                    end
                    acc <= '0;
                    idx <= '0;
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + KW'(1);
                    if (idx == LAST) begin
                        acc_fir_data_in <= sat_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_acc_engine.sv
// tb/tb_fir_acc_engine.sv - self-checking bench for fir_acc_engine
module tb_fir_acc_engine;

    localparam int TAPS = 4;

    logic        clk;
    logic        reset;
    logic        fir_enable;
    logic        to_fir_empty;
    logic [31:0] acc_fir_data_out;
    logic        acc_fir_get;
    logic        from_fir_full;
    logic        acc_fir_put;
    logic [31:0] acc_fir_data_in;
    logic        busy;

    fir_acc_engine #(.TAPS(TAPS), .SAMPLE_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .fir_enable       (fir_enable),
        .to_fir_empty     (to_fir_empty),
        .acc_fir_data_out (acc_fir_data_out),
        .acc_fir_get      (acc_fir_get),
        .from_fir_full    (from_fir_full),
        .acc_fir_put      (acc_fir_put),
        .acc_fir_data_in  (acc_fir_data_in),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_coef;
        logic [31:0] val;
    } word_t;

    word_t       in_q [$];
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_err    = 0;
    int cycle    = 0;
    int last_get_cycle = 0;
    int n_gets   = 0;
    int n_puts   = 0;
    logic        starve = 1'b0;
    logic        lat_on = 1'b1;
    logic        seen_get;
    logic        seen_put;
    logic [31:0] last_put = '0;

    logic signed [15:0] m_coef [TAPS];
    logic signed [15:0] m_x    [TAPS];
    int m_cidx    = 0;
    int m_samples = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cidx    = 0;
        m_samples = 0;
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = '0;
            m_x[i]    = '0;
        end
    endtask

    // Reference FIR: applied only to words the DUT actually pops.
    task automatic model_pop(input word_t w);
        longint s;
        int a;
        int b;
        if (w.is_coef) begin
            if (m_cidx < TAPS) m_coef[m_cidx] = w.val[15:0];
            m_cidx++;
        end else begin
            for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0] = w.val[15:0];
            s = 0;
            for (int i = 0; i < TAPS; i++) begin
                a = m_coef[i];
                b = m_x[i];
                s += longint'(a) * longint'(b);
            end
            if (s > 64'sh7FFF_FFFF)       exp_q.push_back(32'h7FFF_FFFF);
            else if (s < -64'sh8000_0000) exp_q.push_back(32'h8000_0000);
            else                          exp_q.push_back(s[31:0]);
            m_samples++;
        end
    endtask

    task automatic push_word(input logic c, input logic [15:0] v);
        word_t w;
        w.is_coef = c;
        w.val     = {16'($urandom), v};
        in_q.push_back(w);
    endtask

    task automatic load_job(input logic [15:0] c0, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [15:0] c3);
        model_clear();
        push_word(1'b1, c0);
        push_word(1'b1, c1);
        push_word(1'b1, c2);
        push_word(1'b1, c3);
        fir_enable = 1'b1;
    endtask

    // One clock: inputs settle, outputs are observed before the edge, then wait to the negedge.
    task automatic step();
        word_t w;
        logic [31:0] e;
        to_fir_empty = starve || (in_q.size() == 0);
        #1;
        seen_get = acc_fir_get;
        seen_put = acc_fir_put;
        if (seen_get && seen_put) chk("get_put_exclusive", 32'(seen_get & seen_put), 32'd0);
        if (seen_get) begin
            n_gets++;
            if (in_q.size() == 0) begin
                chk("pop_while_empty", 32'd1, 32'd0);
            end else begin
                w = in_q.pop_front();
                acc_fir_data_out = w.val;
                model_pop(w);
                if (!w.is_coef) last_get_cycle = cycle;
            end
        end
        if (seen_put) begin
            n_puts++;
            last_put = acc_fir_data_in;
            if (exp_q.size() == 0) begin
                chk("unexpected_put", acc_fir_data_in, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("result", acc_fir_data_in, e);
            end
            if (lat_on) chk("latency", 32'(cycle - last_get_cycle), 32'(TAPS + 2));
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_puts(input string tag, input int n, input int budget);
        int start;
        int b;
        start = n_puts;
        b = 0;
        while ((n_puts - start) < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(n_puts - start), 32'(n));
    endtask

    task automatic wait_sample_get(input int n, input int budget);
        int b;
        b = 0;
        while (m_samples < n && b < budget) begin
            step();
            b++;
        end
        chk("sample_get_timeout", 32'(m_samples), 32'(n));
    endtask

    task automatic end_job(input string tag);
        int b;
        fir_enable = 1'b0;
        b = 0;
        step();
        while (busy && b < 20) begin
            step();
            b++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    int g0;
    int p0;
    logic [31:0] held;

    initial begin
        reset            = 1'b0;
        fir_enable       = 1'b0;
        from_fir_full    = 1'b0;
        acc_fir_data_out = '0;
        to_fir_empty     = 1'b1;
        @(negedge clk);
        run_cycles(2);
        chk("reset_get",  32'(acc_fir_get), 32'd0);
        chk("reset_put",  32'(acc_fir_put), 32'd0);
        chk("reset_data", acc_fir_data_in, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        run_cycles(2);

        // Impulse response.
        load_job(16'd1, 16'd2, 16'd3, 16'd4);
        push_word(1'b0, 16'd1);
        for (int i = 0; i < 4; i++) push_word(1'b0, 16'd0);
        run_until_puts("impulse_puts", 5, 200);
        chk("impulse_last", last_put, 32'd0);
        end_job("impulse_idle");

        // Positive and negative saturation.
        load_job(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) push_word(1'b0, 16'h7FFF);
        run_until_puts("sat_pos_puts", 4, 200);
        chk("sat_pos_4th", last_put, 32'h7FFF_FFFF);
        end_job("sat_pos_idle");
        load_job(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        for (int i = 0; i < 4; i++) push_word(1'b0, 16'h7FFF);
        run_until_puts("sat_neg_puts", 4, 200);
        chk("sat_neg_4th", last_put, 32'h8000_0000);
        end_job("sat_neg_idle");

        // Output backpressure stalls both output and input.
        lat_on        = 1'b0;
        from_fir_full = 1'b1;
        g0 = n_gets;
        p0 = n_puts;
        load_job(16'd1, 16'd2, 16'd3, 16'd4);
        push_word(1'b0, 16'd5);
        push_word(1'b0, 16'd6);
        push_word(1'b0, 16'd7);
        run_cycles(30);
        held = acc_fir_data_in;
        run_cycles(10);
        chk("bp_no_put", 32'(n_puts - p0), 32'd0);
        chk("bp_gets", 32'(n_gets - g0), 32'(TAPS + 1));
        chk("bp_data_stable", acc_fir_data_in, held);
        chk("bp_data_value", acc_fir_data_in, 32'd5);
        from_fir_full = 1'b0;
        step();
        chk("bp_release_put", 32'(seen_put), 32'd1);
        run_until_puts("bp_rest_puts", 2, 100);
        end_job("bp_idle");
        lat_on = 1'b1;

        // Input starvation in both request states.
        starve = 1'b1;
        load_job(16'd2, 16'd0, 16'd0, 16'd0);
        g0 = n_gets;
        run_cycles(8);
        chk("starve_c_gets", 32'(n_gets - g0), 32'd0);
        chk("starve_c_busy", 32'(busy), 32'd1);
        starve = 1'b0;
        run_cycles(1);
        chk("starve_c_release", 32'(n_gets - g0), 32'd1);
        run_cycles(10);
        chk("starve_coefs_done", 32'(n_gets - g0), 32'd4);
        starve = 1'b1;
        push_word(1'b0, 16'd9);
        g0 = n_gets;
        run_cycles(8);
        chk("starve_s_gets", 32'(n_gets - g0), 32'd0);
        chk("starve_s_busy", 32'(busy), 32'd1);
        starve = 1'b0;
        run_until_puts("starve_put", 1, 50);
        chk("starve_value", last_put, 32'd18);
        end_job("starve_idle");

        // Enable drop while the sample is being accumulated.
        load_job(16'd1, 16'd1, 16'd1, 16'd1);
        push_word(1'b0, 16'd3);
        push_word(1'b0, 16'd4);
        wait_sample_get(1, 100);
        step();
        fir_enable = 1'b0;
        run_until_puts("drop_put", 1, 30);
        chk("drop_value", last_put, 32'd3);
        g0 = n_gets;
        run_cycles(20);
        chk("drop_no_gets", 32'(n_gets - g0), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        in_q.delete();

        // Reset in the middle of accumulation.
        load_job(16'd1, 16'd2, 16'd3, 16'd4);
        push_word(1'b0, 16'd7);
        push_word(1'b0, 16'd7);
        wait_sample_get(1, 100);
        step();
        reset      = 1'b0;
        fir_enable = 1'b0;
        in_q.delete();
        step();
        chk("rst_mid_get",  32'(acc_fir_get), 32'd0);
        chk("rst_mid_put",  32'(acc_fir_put), 32'd0);
        chk("rst_mid_data", acc_fir_data_in, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        run_cycles(2);
        load_job(16'd5, 16'd6, 16'd7, 16'd8);
        push_word(1'b0, 16'd1);
        push_word(1'b0, 16'd0);
        run_until_puts("rst_new_puts", 2, 100);
        chk("rst_new_second", last_put, 32'd6);
        end_job("rst_new_idle");

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
